// File: rtl/keccak_f_sequencer_if.sv
// Signal bundle between the Keccak-f round sequencer, the sponge controller and the round block.
// master = sequencer side, slave = environment (sponge controller + round block) side.
interface keccak_f_sequencer_if #(
    parameter int LANE_W  = 64,
    parameter int ROUND_W = 33
);
    logic                           start;
    logic [4:0][4:0][LANE_W-1:0]    state_in;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic [4:0][4:0][LANE_W-1:0]    state_out;
    logic                           rnd_start;
    logic [ROUND_W-1:0]             rnd_round;
    logic [4:0][4:0][LANE_W-1:0]    rnd_A;
    logic                           rnd_valid;
    logic [4:0][4:0][LANE_W-1:0]    rnd_A_final;

    modport master (
        input  start, state_in, rnd_valid, rnd_A_final,
        output busy, done, err, state_out, rnd_start, rnd_round, rnd_A
    );

    modport slave (
        output start, state_in, rnd_valid, rnd_A_final,
        input  busy, done, err, state_out, rnd_start, rnd_round, rnd_A
    );
endinterface

// File: rtl/keccak_f_sequencer.sv
// Drives a single-round Keccak datapath NUM_ROUNDS times, feeding each result back,
// and returns the permuted state with a done pulse; a watchdog flags a stalled round block.
module keccak_f_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int LANE_W     = 64,
    parameter int ROUND_W    = 33,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    keccak_f_sequencer_if.master bus
);
    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } fsm_e;

    localparam int              TMR_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [4:0]      RCTR_LAST = 5'(NUM_ROUNDS - 1);

    fsm_e             fsm_q, fsm_d;
    state_t           st_q, st_d;
    state_t           out_q, out_d;
    logic [4:0]       rctr_q, rctr_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            st_q    <= '0;
            out_q   <= '0;
            rctr_q  <= '0;
            timer_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            out_q   <= out_d;
            rctr_q  <= rctr_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        out_d   = out_q;
        rctr_d  = rctr_q;
        timer_d = timer_q;
        unique case (fsm_q)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
                    st_d   = bus.state_in;
                    rctr_d = '0;
                    fsm_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                fsm_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rnd_valid) begin
                    st_d = bus.rnd_A_final;
                    if (rctr_q == RCTR_LAST) begin
                        // Load the output on the same edge so data and done coincide.
                        out_d = bus.rnd_A_final;
                        fsm_d = S_DONE;
                    end else begin
                        rctr_d = rctr_q + 5'd1;
                        fsm_d  = S_ISSUE;
                    end
                end else begin
                    // A result arriving in the final allowed cycle still beats the watchdog.
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_d == TMR_LAST) begin
                        fsm_d = S_ERR;
                    end
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (fsm_q == S_ISSUE) || (fsm_q == S_WAIT) || (fsm_q == S_DONE);
    assign bus.done      = (fsm_q == S_DONE);
    assign bus.err       = (fsm_q == S_ERR);
    assign bus.rnd_start = (fsm_q == S_ISSUE);
    assign bus.rnd_round = ROUND_W'(rctr_q);
    assign bus.rnd_A     = st_q;
    assign bus.state_out = out_q;
endmodule
